// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_if
//  Description : Groups the raw push-button / pause-switch inputs, the game
//                tick and the sticky request outputs of button_conditioner.
//                master : drives raw inputs and game_tick, reads requests
//                slave  : reads raw inputs and game_tick, drives requests
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
    logic button_down;
    logic button_rotate;
    logic button_left;
    logic button_right;
    logic sw_pause;
    logic game_tick;
    logic req_down;
    logic req_rotate;
    logic req_left;
    logic req_right;
    logic pause;

    modport master (
        output button_down, button_rotate, button_left, button_right,
        output sw_pause, game_tick,
        input  req_down, req_rotate, req_left, req_right, pause
    );

    modport slave (
        input  button_down, button_rotate, button_left, button_right,
        input  sw_pause, game_tick,
        output req_down, req_rotate, req_left, req_right, pause
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronises, debounces and auto-repeats the four raw game
//                buttons and the pause switch, and holds each resulting move
//                event as a sticky request until the game tick consumes it.
//  Ports       : clk_50   - 50 MHz system clock
//                reset_n  - asynchronous active-low reset
//                bus      - slave side of button_conditioner_if
//                           (raw buttons, sw_pause, game_tick in;
//                            req_down/rotate/left/right, pause out)
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int         BTN_ACTIVE_LOW  = 1,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 15000000,
    parameter int         REPEAT_RATE     = 5000000,
    parameter logic [3:0] REPEAT_EN       = 4'b1011,
    parameter int         CNT_W           = 24
) (
    input  wire logic           clk_50,
    input  wire logic           reset_n,
    button_conditioner_if.slave bus
);
    // Input index map: 0 right, 1 left, 2 rotate, 3 down, 4 pause switch
    localparam int N_IN = 5;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_IN-1:0] raw_norm;
    logic [N_IN-1:0] sync_1;
    logic [N_IN-1:0] sync_2;
    logic [N_IN-1:0] stable;
    logic [3:0]      event_btn;
    logic [3:0]      req;
    logic [3:0]      req_nx;
    logic [3:0]      req_keep;

    // Normalise polarity before synchronising so reset loads 0 = inactive
    always_comb begin
        raw_norm[4]   = bus.sw_pause;
        raw_norm[3:0] = {bus.button_down, bus.button_rotate,
                         bus.button_left, bus.button_right};
        if (BTN_ACTIVE_LOW != 0) begin
            raw_norm[3:0] = ~raw_norm[3:0];
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw_norm;
            sync_2 <= sync_1;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_debounce
            logic [CNT_W-1:0] cnt;
            logic             stable_q;

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync_2[i] == stable_q) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    stable_q <= sync_2[i];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end

            assign stable[i] = stable_q;
        end
    endgenerate

    // Per-button press / auto-repeat sequencer
    generate
        for (genvar i = 0; i < 4; i++) begin : g_repeat
            state_t           state;
            state_t           state_nx;
            logic [CNT_W-1:0] rcnt;
            logic [CNT_W-1:0] rcnt_nx;
            logic             ev;

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    state <= ST_IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_nx;
                    rcnt  <= rcnt_nx;
                end
            end

            always_comb begin
                state_nx = state;
                rcnt_nx  = rcnt;
                ev       = 1'b0;
                if (!stable[i]) begin
                    state_nx = ST_IDLE;
                    rcnt_nx  = '0;
                end else begin
                    case (state)
                        // Being in IDLE with stable high means it has just risen
                        ST_IDLE: begin
                            ev       = 1'b1;
                            state_nx = ST_DELAY;
                            rcnt_nx  = '0;
                        end
                        // Without repeat enabled the button parks here until release
                        ST_DELAY: begin
                            if (REPEAT_EN[i]) begin
                                if (rcnt == DLY_LAST) begin
                                    ev       = 1'b1;
                                    state_nx = ST_REPEAT;
                                    rcnt_nx  = '0;
                                end else begin
                                    rcnt_nx = rcnt + CNT_ONE;
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (rcnt == RATE_LAST) begin
                                ev      = 1'b1;
                                rcnt_nx = '0;
                            end else begin
                                rcnt_nx = rcnt + CNT_ONE;
                            end
                        end
                        default: begin
                            state_nx = ST_IDLE;
                            rcnt_nx  = '0;
                        end
                    endcase
                end
            end

            assign event_btn[i] = ev;
        end
    endgenerate

    // Sticky requests: an event beats the tick; left and right cancel each other
    always_comb begin
        req_keep = bus.game_tick ? 4'b0000 : req;
        req_nx   = req_keep | event_btn;
        if (event_btn[1]) begin
            req_nx[0] = 1'b0;
        end
        if (event_btn[0]) begin
            req_nx[1] = 1'b0;
        end
        if (stable[4]) begin
            req_nx = 4'b0000;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            req <= 4'b0000;
        end else begin
            req <= req_nx;
        end
    end

    assign bus.req_right  = req[0];
    assign bus.req_left   = req[1];
    assign bus.req_rotate = req[2];
    assign bus.req_down   = req[3];
    assign bus.pause      = stable[4];

endmodule
`default_nettype wire
